// File: rtl/axi_slv_rd_pkg.sv
// AXI read responder shared encodings, widths and capture-time checks.
// Width defines are provided here when no global AXI defines exist.
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_SIZE_WIDTH
`define AXI_SIZE_WIDTH 3
`endif
`ifndef AXI_BURST_WIDTH
`define AXI_BURST_WIDTH 2
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_RESP_WIDTH
`define AXI_RESP_WIDTH 2
`endif

package axi_slv_rd_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } resp_e;

  localparam logic [2:0] SIZE_1B   = 3'd0;
  localparam logic [2:0] SIZE_2B   = 3'd1;
  localparam logic [2:0] SIZE_4B   = 3'd2;
  localparam logic [2:0] SIZE_8B   = 3'd3;
  localparam logic [2:0] SIZE_16B  = 3'd4;
  localparam logic [2:0] SIZE_32B  = 3'd5;
  localparam logic [2:0] SIZE_64B  = 3'd6;
  localparam logic [2:0] SIZE_128B = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LAT  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam int unsigned DATA_BYTES = `AXI_DATA_WIDTH / 8;

  // Beat size must fit in the data bus.
  function automatic logic size_ok(
    input logic [`AXI_SIZE_WIDTH-1:0] size
  );
    return (32'd1 << size) <= 32'(DATA_BYTES);
  endfunction

  // WRAP bursts are legal only for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(
    input logic [`AXI_LEN_WIDTH-1:0] len
  );
    return (len == 1) || (len == 3) ||
           (len == 7) || (len == 15);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next beat address for FIXED, INCR and WRAP bursts.
// Purely combinational; shared by read and write responders.
module axi_burst_addr_gen
  import axi_slv_rd_pkg::*;
(
  input  logic [`AXI_ADDR_WIDTH-1:0]  cur_addr,
  input  logic [`AXI_SIZE_WIDTH-1:0]  size,
  input  logic [`AXI_LEN_WIDTH-1:0]   len,
  input  logic [`AXI_BURST_WIDTH-1:0] burst,
  output logic [`AXI_ADDR_WIDTH-1:0]  next_addr
);

  localparam int AW = `AXI_ADDR_WIDTH;

  logic [AW-1:0] bytes;
  logic [AW-1:0] aligned;
  logic [AW-1:0] incr;
  logic [AW-1:0] wmask;

  assign bytes   = AW'(1) << size;
  assign aligned = cur_addr & ~(bytes - AW'(1));
  assign incr    = aligned + bytes;
  // Container size minus one: len*bytes has clear low bits.
  assign wmask   = (AW'(len) << size) | (bytes - AW'(1));

  // Select the burst-type address update.
  always_comb begin
    next_addr = incr;
    case (burst)
      BURST_FIXED: next_addr = cur_addr;
      BURST_WRAP:  next_addr = (cur_addr & ~wmask) |
                               (incr & wmask);
      default:     next_addr = incr;
    endcase
  end

endmodule

// File: rtl/axi_slv_rd.sv
// AXI read responder: one burst at a time, address-derived data.
// AXI_SLV_RD_GAP_EN inserts one idle cycle between beats.
module axi_slv_rd
  import axi_slv_rd_pkg::*;
#(
  parameter logic [`AXI_ADDR_WIDTH-1:0] BASE_ADDR  = 'h0,
  parameter logic [`AXI_ADDR_WIDTH-1:0] ADDR_RANGE = 'h1000,
  parameter int unsigned                RD_LATENCY = 2
)(
  input  logic                        clk,
  input  logic                        rst,
  input  logic [`AXI_ID_WIDTH-1:0]    axi_slv_arid,
  input  logic [`AXI_ADDR_WIDTH-1:0]  axi_slv_araddr,
  input  logic [`AXI_LEN_WIDTH-1:0]   axi_slv_arlen,
  input  logic [`AXI_SIZE_WIDTH-1:0]  axi_slv_arsize,
  input  logic [`AXI_BURST_WIDTH-1:0] axi_slv_arburst,
  input  logic                        axi_slv_arvalid,
  output logic                        axi_slv_arready,
  output logic [`AXI_ID_WIDTH-1:0]    axi_slv_rid,
  output logic [`AXI_DATA_WIDTH-1:0]  axi_slv_rdata,
  output logic [`AXI_RESP_WIDTH-1:0]  axi_slv_rresp,
  output logic                        axi_slv_rlast,
  output logic                        axi_slv_rvalid,
  input  logic                        axi_slv_rready
);

  localparam int AW  = `AXI_ADDR_WIDTH;
  localparam int DW  = `AXI_DATA_WIDTH;
  localparam int IW  = `AXI_ID_WIDTH;
  localparam int LW  = `AXI_LEN_WIDTH;
  localparam int SW  = `AXI_SIZE_WIDTH;
  localparam int BW  = `AXI_BURST_WIDTH;

  localparam logic [AW:0] LO_X = {1'b0, BASE_ADDR};
  localparam logic [AW:0] HI_X = {1'b0, BASE_ADDR} +
                                 {1'b0, ADDR_RANGE};

  state_e         state_q, state_d;
  logic           arready_q, arready_d;
  logic [3:0]     lat_q, lat_d;
  logic [IW-1:0]  id_q, id_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [LW-1:0]  len_q, len_d;
  logic [SW-1:0]  size_q, size_d;
  logic [BW-1:0]  burst_q, burst_d;
  logic [LW-1:0]  beat_q, beat_d;
  logic           slverr_q, slverr_d;
`ifdef AXI_SLV_RD_GAP_EN
  logic           gap_q, gap_d;
`endif

  logic           rvalid;
  logic           last;
  logic           ar_hs;
  logic           r_hs;
  logic           decerr;
  logic [AW:0]    addr_x;
  logic [1:0]     resp;
  logic [AW-1:0]  next_addr;

  axi_burst_addr_gen u_addr_gen (
    .cur_addr  (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

`ifdef AXI_SLV_RD_GAP_EN
  assign rvalid = (state_q == ST_DATA) && !gap_q;
`else
  assign rvalid = (state_q == ST_DATA);
`endif

  assign last   = (beat_q == len_q);
  assign ar_hs  = axi_slv_arvalid && arready_q;
  assign r_hs   = rvalid && axi_slv_rready;
  // Extra top bit keeps the window compare free of wrap-around.
  assign addr_x = {1'b0, addr_q};
  assign decerr = (addr_x < LO_X) || (addr_x >= HI_X);
  assign resp   = slverr_q ? RESP_SLVERR :
                  decerr   ? RESP_DECERR : RESP_OKAY;

  assign axi_slv_arready = arready_q;
  assign axi_slv_rvalid  = rvalid;
  assign axi_slv_rlast   = rvalid && last;
  assign axi_slv_rid     = rvalid ? id_q : '0;
  assign axi_slv_rresp   = rvalid ? resp : RESP_OKAY;
  assign axi_slv_rdata   = (rvalid && resp == RESP_OKAY) ?
                           DW'(addr_q) : '0;

  // Next-state: AR capture, latency count, beat sequencing.
  always_comb begin
    state_d   = state_q;
    arready_d = arready_q;
    lat_d     = lat_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    beat_d    = beat_q;
    slverr_d  = slverr_q;
`ifdef AXI_SLV_RD_GAP_EN
    gap_d     = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          arready_d = 1'b0;
          id_d      = axi_slv_arid;
          addr_d    = axi_slv_araddr;
          len_d     = axi_slv_arlen;
          size_d    = axi_slv_arsize;
          burst_d   = axi_slv_arburst;
          beat_d    = '0;
          lat_d     = '0;
          slverr_d  = (axi_slv_arburst == BURST_RSVD) ||
                      ((axi_slv_arburst == BURST_WRAP) &&
                       !wrap_len_ok(axi_slv_arlen)) ||
                      !size_ok(axi_slv_arsize);
          state_d   = (RD_LATENCY == 0) ? ST_DATA : ST_LAT;
        end
      end
      ST_LAT: begin
        if (lat_q == 4'(RD_LATENCY - 1)) begin
          state_d = ST_DATA;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
      ST_DATA: begin
        if (r_hs) begin
          if (last) begin
            state_d   = ST_IDLE;
            arready_d = 1'b1;
            beat_d    = '0;
          end else begin
            beat_d = beat_q + LW'(1);
            addr_d = next_addr;
`ifdef AXI_SLV_RD_GAP_EN
            gap_d  = 1'b1;
`endif
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and burst context registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      arready_q <= 1'b0;
      lat_q     <= '0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      beat_q    <= '0;
      slverr_q  <= 1'b0;
`ifdef AXI_SLV_RD_GAP_EN
      gap_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      lat_q     <= lat_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      beat_q    <= beat_d;
      slverr_q  <= slverr_d;
`ifdef AXI_SLV_RD_GAP_EN
      gap_q     <= gap_d;
`endif
    end
  end

endmodule
